attack_sequencer: RTL and testbench
===================================

Name: attack_sequencer

Overview:
- Parametrised successor to player_attack: frame-timed attack engine for N attack types.
- Each attack runs through startup, active and recovery phases, advanced by SCEN (one pulse per video frame).
- Emits a facing-aware, registered hitbox for the renderer and hit detector, with a one-hit-per-swing handshake.
- Sits between the button inputs / player_move outputs and the collision and draw logic in the top level.

Parameters:
NUM_ATK, 2, number of attack types (1..8)
CNT_W, 6, phase frame-counter width
POS_W, 10, pixel coordinate width
BOX_W, 60, player body width in pixels
STARTUP_F, {6'd3,6'd2}, packed NUM_ATK*CNT_W startup frame counts, index 0 in LSBs, each >=1
ACTIVE_F, {6'd4,6'd3}, packed active frame counts, each >=1
RECOVER_F, {6'd6,6'd4}, packed recovery frame counts, each >=1
HIT_W, {10'd60,10'd30}, packed NUM_ATK*POS_W hitbox widths
HIT_H, {10'd40,10'd60}, packed hitbox heights

Ports:
clk  in  1  pixel clock (25 MHz)
reset_n  in  1  asynchronous reset, active-low
SCEN  in  1  frame tick, 1-cycle pulse
attack_enable  in  1  low = attacks disallowed / abort
attack_req  in  NUM_ATK  level request per type
facing_right  in  1  from player_move
pos_x  in  POS_W  player left edge
pos_y  in  POS_W  player top edge
hit_confirm  in  1  collision logic reports contact
attack_busy  out  1  state != IDLE
attack_active  out  1  state == ACTIVE
attack_type  out  $clog2(NUM_ATK)+1  1-based type, 0 when idle
phase  out  2  0 idle, 1 startup, 2 active, 3 recovery
hitbox_valid  out  1  ACTIVE and no hit landed yet
hit_x0  out  POS_W  inclusive left edge
hit_x1  out  POS_W  exclusive right edge
hit_y0  out  POS_W  top edge
hit_y1  out  POS_W  exclusive bottom edge
hit_pulse  out  1  one-cycle pulse on accepted hit

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, counter 0, hit_landed 0.
- FSM states are IDLE, STARTUP, ACTIVE, RECOVERY. Transitions occur only on clk edges where SCEN=1, except the abort case.
- IDLE to STARTUP:
  - Requires SCEN & attack_enable & |attack_req.
  - Lowest set request index wins; attack_type is latched as index+1.
  - Counter loads STARTUP_F[type]-1.
- Within a phase: on SCEN with counter != 0, decrement the counter.
  - On SCEN with counter == 0, advance STARTUP->ACTIVE, ACTIVE->RECOVERY, RECOVERY->IDLE.
  - Each advance loads the next phase length minus 1.
  - Net effect: a phase lasts exactly its configured number of SCEN pulses.
- Requests are ignored while busy; attack_type stays constant for the whole swing.
- Abort: attack_enable low in any non-IDLE state forces IDLE on the next clk, regardless of SCEN. attack_type clears to 0 and hit_landed clears.
- Hitbox: registered every clk, so 1-cycle latency from pos_x, pos_y and facing_right.
  - facing_right=1: x0 = pos_x+BOX_W, x1 = x0+HIT_W.
  - facing_right=0: x0 = pos_x-HIT_W, saturating at 0; x1 = pos_x.
  - y0 = pos_y, y1 = pos_y+HIT_H.
  - Arithmetic is done at POS_W+1 bits; x1 and y1 saturate at 2^POS_W-1.
  - Hitbox coordinates hold 0 when not ACTIVE.
- Hit handshake:
  - hit_confirm while hitbox_valid sets hit_landed and produces hit_pulse for exactly 1 cycle.
  - hitbox_valid drops on the following cycle.
  - hit_confirm is ignored otherwise.
  - hit_landed clears on entry to STARTUP.
- Simultaneous SCEN and hit_confirm on the last ACTIVE frame: the hit is accepted (hit_pulse=1) and the FSM still moves to RECOVERY.

Optional Feature:
- Macro ATTACK_BUFFER_EN.
- Defined: a rising edge of any attack_req during RECOVERY is stored in a 1-entry buffer. Lowest index wins; later requests overwrite only if their index is lower.
  - On RECOVERY->IDLE, a buffered request goes directly to STARTUP (no idle frame), provided attack_enable=1.
  - The buffer clears on abort and on reset.
- Undefined: no buffer; requests made during a swing are lost.

Decomposition:
- Shared package fighter_pkg holds:
  - phase encodings (PH_IDLE..PH_RECOVER);
  - POS_W default;
  - BOX_W;
  - GROUND_Y.
- One natural sub-module: attack_hitbox_calc, holding the registered, facing-aware, saturating hitbox arithmetic. It is reused later for player 2.

Test Plan:
- Tap attack_req=2'b01 at one SCEN, default parameters:
  - phase must be 1 for 2 SCENs, then 2 for 3, then 3 for 4, then 0;
  - attack_busy must be high for exactly 9 frames.
- pos_x=100, pos_y=300, facing_right=1, type 1, ACTIVE: hit = (160,190,300,360). With facing_right=0: hit = (70,100,300,360).
- pos_x=20, facing left, type 2: hit_x0=0 (saturated), hit_x1=20, hit_y1 = pos_y+40.
- attack_req=2'b11 simultaneously: attack_type must be 1.
- Repeated hit_confirm during ACTIVE: exactly one hit_pulse, and hitbox_valid low from the next cycle.
- Deassert attack_enable mid-STARTUP: IDLE and all outputs 0 on the next clk without SCEN. Assert reset_n=0 mid-ACTIVE: immediate all-zero outputs.
- ATTACK_BUFFER_EN: press type 2 during RECOVERY of type 1: STARTUP of type 2 begins on the same SCEN that ends RECOVERY. Without the macro: return to IDLE.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared fighter-game definitions: attack phase encodings and playfield geometry.
package fighter_pkg;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_STARTUP = 2'd1,
        PH_ACTIVE  = 2'd2,
        PH_RECOVER = 2'd3
    } phase_e;

    localparam int DEF_POS_W = 10;
    localparam int DEF_BOX_W = 60;
    localparam int GROUND_Y  = 420;

endpackage

// File: rtl/attack_hitbox_calc.sv
// Registered, facing-aware attack hitbox; coordinates saturate to the pixel range
// and read zero whenever the hitbox is not enabled.
module attack_hitbox_calc
    import fighter_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int BOX_W = DEF_BOX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             facing_right_i,
    input  logic [POS_W-1:0] pos_x_i,
    input  logic [POS_W-1:0] pos_y_i,
    input  logic [POS_W-1:0] hit_w_i,
    input  logic [POS_W-1:0] hit_h_i,
    output logic [POS_W-1:0] x0_o,
    output logic [POS_W-1:0] x1_o,
    output logic [POS_W-1:0] y0_o,
    output logic [POS_W-1:0] y1_o
);

    localparam logic [POS_W:0] BOX_EXT = (POS_W+1)'(BOX_W);

    logic [POS_W:0]   right_x0, right_x1, left_x0, y1_ext;
    logic [POS_W-1:0] x0_d, x1_d, y0_d, y1_d;
    logic [POS_W-1:0] x0_q, x1_q, y0_q, y1_q;

    // Operands never exceed 2^POS_W-1, so a carry into the top bit means overflow.
    function automatic logic [POS_W-1:0] sat(input logic [POS_W:0] v);
        return v[POS_W] ? {POS_W{1'b1}} : v[POS_W-1:0];
    endfunction

    always_comb begin
        right_x0 = {1'b0, pos_x_i} + BOX_EXT;
        right_x1 = {1'b0, sat(right_x0)} + {1'b0, hit_w_i};
        left_x0  = {1'b0, pos_x_i} - {1'b0, hit_w_i};
        y1_ext   = {1'b0, pos_y_i} + {1'b0, hit_h_i};
        x0_d = '0;
        x1_d = '0;
        y0_d = '0;
        y1_d = '0;
        if (en_i) begin
            if (facing_right_i) begin
                x0_d = sat(right_x0);
                x1_d = sat(right_x1);
            end else begin
                x0_d = left_x0[POS_W] ? '0 : left_x0[POS_W-1:0];
                x1_d = pos_x_i;
            end
            y0_d = pos_y_i;
            y1_d = sat(y1_ext);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else begin
            x0_q <= x0_d;
            x1_q <= x1_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
        end
    end

    assign x0_o = x0_q;
    assign x1_o = x1_q;
    assign y0_o = y0_q;
    assign y1_o = y1_q;

endmodule

// File: rtl/attack_sequencer.sv
// Frame-timed attack engine: NUM_ATK attack types sequenced through startup, active and
// recovery on SCEN. Define ATTACK_BUFFER_EN to queue one follow-up attack pressed in recovery.
module attack_sequencer
    import fighter_pkg::*;
#(
    parameter int                       NUM_ATK   = 2,
    parameter int                       CNT_W     = 6,
    parameter int                       POS_W     = DEF_POS_W,
    parameter int                       BOX_W     = DEF_BOX_W,
    parameter logic [NUM_ATK*CNT_W-1:0] STARTUP_F = {6'd3, 6'd2},
    parameter logic [NUM_ATK*CNT_W-1:0] ACTIVE_F  = {6'd4, 6'd3},
    parameter logic [NUM_ATK*CNT_W-1:0] RECOVER_F = {6'd6, 6'd4},
    parameter logic [NUM_ATK*POS_W-1:0] HIT_W     = {10'd60, 10'd30},
    parameter logic [NUM_ATK*POS_W-1:0] HIT_H     = {10'd40, 10'd60}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      SCEN,
    input  logic                      attack_enable,
    input  logic [NUM_ATK-1:0]        attack_req,
    input  logic                      facing_right,
    input  logic [POS_W-1:0]          pos_x,
    input  logic [POS_W-1:0]          pos_y,
    input  logic                      hit_confirm,
    output logic                      attack_busy,
    output logic                      attack_active,
    output logic [$clog2(NUM_ATK):0]  attack_type,
    output logic [1:0]                phase,
    output logic                      hitbox_valid,
    output logic [POS_W-1:0]          hit_x0,
    output logic [POS_W-1:0]          hit_x1,
    output logic [POS_W-1:0]          hit_y0,
    output logic [POS_W-1:0]          hit_y1,
    output logic                      hit_pulse
);

    localparam int IDX_W  = (NUM_ATK > 1) ? $clog2(NUM_ATK) : 1;
    localparam int TYPE_W = $clog2(NUM_ATK) + 1;

    phase_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic              landed_q, landed_d;
    logic              pulse_q, pulse_d;
    logic [IDX_W-1:0]  req_idx, start_idx;
    logic              start_go, valid_now;
    logic [POS_W-1:0]  hit_w_sel, hit_h_sel;

    function automatic logic [CNT_W-1:0] last_frame(input phase_e ph, input logic [IDX_W-1:0] idx);
        logic [CNT_W-1:0] len;
        case (ph)
            PH_STARTUP: len = STARTUP_F[int'(idx)*CNT_W +: CNT_W];
            PH_ACTIVE:  len = ACTIVE_F[int'(idx)*CNT_W +: CNT_W];
            default:    len = RECOVER_F[int'(idx)*CNT_W +: CNT_W];
        endcase
        return len - CNT_W'(1);
    endfunction

    always_comb begin
        req_idx = '0;
        for (int i = NUM_ATK - 1; i >= 0; i--)
            if (attack_req[i]) req_idx = IDX_W'(i);
    end

`ifdef ATTACK_BUFFER_EN
    logic [NUM_ATK-1:0] req_prev_q, req_rise;
    logic               buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0]   buf_idx_q, buf_idx_d, rise_idx;

    assign req_rise = attack_req & ~req_prev_q;

    always_comb begin
        rise_idx = '0;
        for (int i = NUM_ATK - 1; i >= 0; i--)
            if (req_rise[i]) rise_idx = IDX_W'(i);
    end
`endif

    assign valid_now = (state_q == PH_ACTIVE) && !landed_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        type_d    = type_q;
        landed_d  = landed_q;
        pulse_d   = 1'b0;
        start_go  = 1'b0;
        start_idx = req_idx;
`ifdef ATTACK_BUFFER_EN
        buf_vld_d = buf_vld_q;
        buf_idx_d = buf_idx_q;
`endif
        if (state_q != PH_IDLE && !attack_enable) begin
            state_d  = PH_IDLE;
            cnt_d    = '0;
            type_d   = '0;
            landed_d = 1'b0;
`ifdef ATTACK_BUFFER_EN
            buf_vld_d = 1'b0;
`endif
        end else begin
            if (hit_confirm && valid_now) begin
                landed_d = 1'b1;
                pulse_d  = 1'b1;
            end
`ifdef ATTACK_BUFFER_EN
            if (state_q == PH_RECOVER && |req_rise && (!buf_vld_q || rise_idx < buf_idx_q)) begin
                buf_vld_d = 1'b1;
                buf_idx_d = rise_idx;
            end
`endif
            if (SCEN) begin
                if (state_q == PH_IDLE) begin
                    start_go = attack_enable && |attack_req;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        PH_STARTUP: begin
                            state_d = PH_ACTIVE;
                            cnt_d   = last_frame(PH_ACTIVE, idx_q);
                        end
                        PH_ACTIVE: begin
                            state_d = PH_RECOVER;
                            cnt_d   = last_frame(PH_RECOVER, idx_q);
                        end
                        default: begin
                            state_d = PH_IDLE;
                            type_d  = '0;
`ifdef ATTACK_BUFFER_EN
                            // A press queued during recovery chains straight into the next startup.
                            start_go  = buf_vld_d;
                            start_idx = buf_idx_d;
                            buf_vld_d = 1'b0;
`endif
                        end
                    endcase
                end
            end
        end
        if (start_go) begin
            state_d  = PH_STARTUP;
            idx_d    = start_idx;
            type_d   = TYPE_W'(start_idx) + TYPE_W'(1);
            cnt_d    = last_frame(PH_STARTUP, start_idx);
            landed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PH_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            type_q   <= '0;
            landed_q <= 1'b0;
            pulse_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
            req_prev_q <= '0;
            buf_vld_q  <= 1'b0;
            buf_idx_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            type_q   <= type_d;
            landed_q <= landed_d;
            pulse_q  <= pulse_d;
`ifdef ATTACK_BUFFER_EN
            req_prev_q <= attack_req;
            buf_vld_q  <= buf_vld_d;
            buf_idx_q  <= buf_idx_d;
`endif
        end
    end

    assign hit_w_sel = HIT_W[int'(idx_d)*POS_W +: POS_W];
    assign hit_h_sel = HIT_H[int'(idx_d)*POS_W +: POS_W];

    // Driven from next state so the hitbox registers in the same cycle attack_active rises.
    attack_hitbox_calc #(
        .POS_W (POS_W),
        .BOX_W (BOX_W)
    ) u_hitbox (
        .clk            (clk),
        .reset_n        (reset_n),
        .en_i           (state_d == PH_ACTIVE),
        .facing_right_i (facing_right),
        .pos_x_i        (pos_x),
        .pos_y_i        (pos_y),
        .hit_w_i        (hit_w_sel),
        .hit_h_i        (hit_h_sel),
        .x0_o           (hit_x0),
        .x1_o           (hit_x1),
        .y0_o           (hit_y0),
        .y1_o           (hit_y1)
    );

    assign attack_busy   = (state_q != PH_IDLE);
    assign attack_active = (state_q == PH_ACTIVE);
    assign attack_type   = type_q;
    assign phase         = state_q;
    assign hitbox_valid  = valid_now;
    assign hit_pulse     = pulse_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Self-checking bench for attack_sequencer: frame-count reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_attack_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SCEN = 1'b0;
    logic       attack_enable = 1'b0;
    logic [1:0] attack_req = 2'b00;
    logic       facing_right = 1'b0;
    logic [9:0] pos_x = 10'd0;
    logic [9:0] pos_y = 10'd0;
    logic       hit_confirm = 1'b0;

    logic       attack_busy, attack_active, hitbox_valid, hit_pulse;
    logic [1:0] attack_type, phase;
    logic [9:0] hit_x0, hit_x1, hit_y0, hit_y1;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    attack_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SCEN          (SCEN),
        .attack_enable (attack_enable),
        .attack_req    (attack_req),
        .facing_right  (facing_right),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .hit_confirm   (hit_confirm),
        .attack_busy   (attack_busy),
        .attack_active (attack_active),
        .attack_type   (attack_type),
        .phase         (phase),
        .hitbox_valid  (hitbox_valid),
        .hit_x0        (hit_x0),
        .hit_x1        (hit_x1),
        .hit_y0        (hit_y0),
        .hit_y1        (hit_y1),
        .hit_pulse     (hit_pulse)
    );

    // Reference tables for the default configuration, indexed by type-1.
    int S_F[2] = '{2, 3};
    int A_F[2] = '{3, 4};
    int R_F[2] = '{4, 6};
    int HW[2]  = '{30, 60};
    int HH[2]  = '{60, 40};

    // Model: a swing is described by its type and the SCEN count since it started.
    int m_type = 0, m_el = 0, m_landed = 0, m_pulse = 0, m_buf = 0;
    int m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;
    int m_ph, m_rise, m_t, m_px, m_py;
    logic [1:0] m_prev_req = 2'b00;

    function automatic int m_phase(input int t, input int e);
        if (t == 0) return 0;
        if (e < S_F[t-1]) return 1;
        if (e < S_F[t-1] + A_F[t-1]) return 2;
        return 3;
    endfunction

    function automatic int lowest(input logic [1:0] r);
        if (r[0]) return 1;
        if (r[1]) return 2;
        return 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_type = 0; m_el = 0; m_landed = 0; m_pulse = 0; m_buf = 0;
            m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_prev_req = 2'b00;
        end else begin
            m_ph = m_phase(m_type, m_el);
            m_pulse = 0;
            if (m_type != 0 && !attack_enable) begin
                m_type = 0; m_el = 0; m_landed = 0; m_buf = 0;
            end else begin
                if (hit_confirm && m_ph == 2 && m_landed == 0) begin
                    m_pulse = 1;
                    m_landed = 1;
                end
                if (m_ph == 3) begin
                    m_rise = lowest(attack_req & ~m_prev_req);
                    if (m_rise != 0 && (m_buf == 0 || m_rise < m_buf)) m_buf = m_rise;
                end
                if (SCEN) begin
                    if (m_type == 0) begin
                        if (attack_enable && attack_req != 2'b00) begin
                            m_type = lowest(attack_req); m_el = 0; m_landed = 0;
                        end
                    end else begin
                        m_el++;
                        if (m_el == S_F[m_type-1] + A_F[m_type-1] + R_F[m_type-1]) begin
                            m_type = 0; m_el = 0;
`ifdef ATTACK_BUFFER_EN
                            if (m_buf != 0) begin
                                m_type = m_buf; m_landed = 0;
                            end
`endif
                            m_buf = 0;
                        end
                    end
                end
            end
            m_prev_req = attack_req;
            if (m_phase(m_type, m_el) == 2) begin
                m_t = m_type - 1; m_px = int'(pos_x); m_py = int'(pos_y);
                if (facing_right) begin
                    m_x0 = imin(m_px + 60, 1023);
                    m_x1 = imin(m_x0 + HW[m_t], 1023);
                end else begin
                    m_x0 = (m_px - HW[m_t] < 0) ? 0 : m_px - HW[m_t];
                    m_x1 = m_px;
                end
                m_y0 = m_py;
                m_y1 = imin(m_py + HH[m_t], 1023);
            end else begin
                m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
            end
        end
    end

    function automatic logic [47:0] dut_outs();
        return {attack_busy, attack_active, attack_type, phase, hitbox_valid,
                hit_x0, hit_x1, hit_y0, hit_y1, hit_pulse};
    endfunction

    initial forever begin
        logic [47:0] exp_v, act_v;
        int ph;
        @(negedge clk);
        if (cmp_en) begin
            ph = m_phase(m_type, m_el);
            exp_v = {(m_type != 0), (ph == 2), 2'(m_type), 2'(ph), (ph == 2 && m_landed == 0),
                     10'(m_x0), 10'(m_x1), 10'(m_y0), 10'(m_y1), 1'(m_pulse)};
            act_v = dut_outs();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [1:0] req);
        attack_req = req;
        SCEN = 1'b1;
        tick();
        attack_req = 2'b00;
        SCEN = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_out();
        for (int i = 0; i < 14; i++) frame(2'b00);
    endtask

    int ph_seen[10];
    int ph_exp[10] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
    int busy_frames = 0;
    int pulses = 0;

    initial begin
        repeat (3) tick();
        check("reset_outputs", 64'(dut_outs()), 64'd0);
        reset_n = 1'b1;
        attack_enable = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Single tap of type 1: 2 startup, 3 active, 4 recovery frames.
        for (int k = 0; k < 10; k++) begin
            frame(k == 0 ? 2'b01 : 2'b00);
            ph_seen[k] = int'(phase);
            busy_frames += int'(attack_busy);
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("tap_phase_%0d", k), 64'(ph_seen[k]), 64'(ph_exp[k]));
        check("tap_busy_frames", 64'(busy_frames), 64'd9);

        // Type 1 hitbox facing right, then facing left.
        pos_x = 10'd100; pos_y = 10'd300; facing_right = 1'b1;
        frame(2'b01); frame(2'b00); frame(2'b00);
        check("geo_phase_active", 64'(phase), 64'd2);
        check("geo_right", 64'({hit_x0, hit_x1, hit_y0, hit_y1}),
              64'({10'd160, 10'd190, 10'd300, 10'd360}));
        facing_right = 1'b0;
        tick();
        check("geo_left", 64'({hit_x0, hit_x1, hit_y0, hit_y1}),
              64'({10'd70, 10'd100, 10'd300, 10'd360}));
        run_out();

        // Type 2 facing left near the screen edge.
        pos_x = 10'd20;
        frame(2'b10); frame(2'b00); frame(2'b00); frame(2'b00);
        check("sat_type", 64'(attack_type), 64'd2);
        check("sat_left", 64'({hit_x0, hit_x1, hit_y0, hit_y1}),
              64'({10'd0, 10'd20, 10'd300, 10'd340}));
        run_out();

        // Simultaneous requests, then abort during startup without SCEN.
        frame(2'b11);
        check("both_req_type", 64'(attack_type), 64'd1);
        check("both_req_phase", 64'(phase), 64'd1);
        attack_enable = 1'b0;
        tick();
        check("abort_outputs", 64'(dut_outs()), 64'd0);
        attack_enable = 1'b1;
        tick();

        // Held hit_confirm during active: exactly one pulse.
        pos_x = 10'd100; facing_right = 1'b1;
        frame(2'b01); frame(2'b00); frame(2'b00);
        hit_confirm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(hit_pulse);
        end
        hit_confirm = 1'b0;
        check("single_hit_pulse", 64'(pulses), 64'd1);
        check("valid_low_after_hit", 64'(hitbox_valid), 64'd0);
        check("still_active_after_hit", 64'(attack_active), 64'd1);
        run_out();

        // Hit on the last active frame together with SCEN.
        frame(2'b01); frame(2'b00); frame(2'b00); frame(2'b00); frame(2'b00);
        hit_confirm = 1'b1;
        SCEN = 1'b1;
        tick();
        check("last_frame_hit_pulse", 64'(hit_pulse), 64'd1);
        check("last_frame_to_recovery", 64'(phase), 64'd3);
        SCEN = 1'b0;
        hit_confirm = 1'b0;
        tick();
        run_out();

        // Asynchronous reset in the middle of active.
        frame(2'b01); frame(2'b00); frame(2'b00);
        check("pre_reset_active", 64'(attack_active), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_active", 64'(dut_outs()), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Type 2 pressed during type 1 recovery.
        frame(2'b01);
        for (int i = 0; i < 5; i++) frame(2'b00);
        check("buf_in_recovery", 64'(phase), 64'd3);
        attack_req = 2'b10;
        tick();
        attack_req = 2'b00;
        tick();
        frame(2'b00); frame(2'b00); frame(2'b00);
        check("buf_still_recovery", 64'(phase), 64'd3);
        frame(2'b00);
`ifdef ATTACK_BUFFER_EN
        check("buf_chain_phase", 64'(phase), 64'd1);
        check("buf_chain_type", 64'(attack_type), 64'd2);
`else
        check("buf_chain_phase", 64'(phase), 64'd0);
        check("buf_chain_type", 64'(attack_type), 64'd0);
`endif
        run_out();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
